// File: rtl/ahb_ram_arbiter_pkg.sv
// Shared types for the two-requester AHB RAM arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        M0,
        M1
    } arb_owner_t;

endpackage

// File: rtl/ahb_ram_arbiter_if.sv
// Bundle of requester handshakes and the AHB RAM bus around the arbiter.
// The master modport is the arbiter's view. It is an AHB master and owns gnt/done.
// The slave modport is the surrounding environment: both cores plus ram_top.
interface ahb_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_done;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_done;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        input  m0_req, m0_addr, m0_we, m0_wdata,
        output m0_gnt, m0_done, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_we, m1_wdata,
        output m1_gnt, m1_done, m1_rdata, m1_err,
        output hsel, haddr, hwrite, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        output m0_req, m0_addr, m0_we, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_we, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata, m1_err,
        input  hsel, haddr, hwrite, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/ahb_ram_arbiter_rr_pick.sv
// Two-way combinational picker.
// It alternates on ties in round-robin mode.
// It favours M1 on ties in fixed-priority mode.
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req_i,
    input  arb_owner_t last_owner_i,
    output arb_owner_t winner_o,
    output logic       valid_o
);

    // Select the winner among the active requests.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        valid_o  = |req_i;
        winner_o = M0;
        case (req_i)
            2'b10:   winner_o = M1;
            2'b11: begin
                if (FIXED_PRIO != 0)        winner_o = M1;
                else if (last_owner_i == M0) winner_o = M1;
                else                         winner_o = M0;
            end
            default: winner_o = M0;
        endcase
    end

endmodule

// File: rtl/ahb_ram_arbiter.sv
// Shares one non-pipelined AHB RAM port between instruction fetch (M0) and load/store (M1).
// Only one transfer is outstanding at a time.
// A timer bounds how long the DATA phase may wait for hready.
module ahb_ram_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    ahb_ram_arbiter_if.master  bus
);

    localparam int            TW         = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, owner_d;
    arb_owner_t            last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic [1:0]            gnt;

    arb_owner_t winner;
    logic       pick_valid;

    ahb_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req_i        ({bus.m1_req, bus.m0_req}),
        .last_owner_i (last_owner_q),
        .winner_o     (winner),
        .valid_o      (pick_valid)
    );

    // Compute the next state, grant, request latch, timer and response for the owner.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        done_d       = '0;
        err_d        = err_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        gnt          = '0;
        case (state_q)
            ARB_IDLE: begin
                // A done pulse still on the outputs holds off the next grant by one cycle.
                if (pick_valid && !rst && done_q == 2'b00) begin
                    if (winner == M1) begin
                        gnt[1]  = 1'b1;
                        addr_d  = bus.m1_addr;
                        we_d    = bus.m1_we;
                        wdata_d = bus.m1_wdata;
                    end else begin
                        gnt[0]  = 1'b1;
                        addr_d  = bus.m0_addr;
                        we_d    = bus.m0_we;
                        wdata_d = bus.m0_wdata;
                    end
                    owner_d      = winner;
                    last_owner_d = winner;
                    state_d      = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                timer_d = '0;
                state_d = ARB_DATA;
            end
            ARB_DATA: begin
                if (bus.hready) begin
                    if (owner_q == M1) begin
                        done_d[1]  = 1'b1;
                        err_d[1]   = bus.hresp;
                        m1_rdata_d = we_q ? '0 : bus.hrdata;
                    end else begin
                        done_d[0]  = 1'b1;
                        err_d[0]   = bus.hresp;
                        m0_rdata_d = we_q ? '0 : bus.hrdata;
                    end
                    state_d = ARB_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    // The slave never answered: report an error and give up on it.
                    if (owner_q == M1) begin
                        done_d[1]  = 1'b1;
                        err_d[1]   = 1'b1;
                        m1_rdata_d = '0;
                    end else begin
                        done_d[0]  = 1'b1;
                        err_d[0]   = 1'b1;
                        m0_rdata_d = '0;
                    end
                    state_d = ARB_IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Register all state; synchronous reset aborts any transfer without a done pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the pre-edge values.
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= M0;
            last_owner_q <= M1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            timer_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            err_q        <= err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign bus.m0_gnt   = gnt[0];
    assign bus.m1_gnt   = gnt[1];
    assign bus.m0_done  = done_q[0];
    assign bus.m1_done  = done_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;

    assign bus.hsel   = (state_q == ARB_ADDR);
    assign bus.haddr  = (state_q == ARB_ADDR) ? addr_q : '0;
    assign bus.hwrite = (state_q == ARB_ADDR) ? we_q : 1'b0;
    assign bus.hwdata = (state_q == ARB_DATA && we_q) ? wdata_q : '0;

endmodule
